// File: rtl/ifu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu_pkg : shared widths, opcode masks, state and FIFO entry types for the IFU
// Rev 1.0
// ----------------------------------------------------------------------------
package ifu_pkg;

  localparam int PC_W   = 14;
  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] JMP_CALL_MASK = 16'hFE0C;
  localparam logic [WORD_W-1:0] JMP_CALL_VAL  = 16'h940C;
  localparam logic [WORD_W-1:0] LDS_STS_MASK  = 16'hFC0F;
  localparam logic [WORD_W-1:0] LDS_STS_VAL   = 16'h9000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] word;
  } ifu_entry_t;

  function automatic logic is_two_word(input logic [WORD_W-1:0] w);
    return ((w & JMP_CALL_MASK) == JMP_CALL_VAL) || ((w & LDS_STS_MASK) == LDS_STS_VAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_word_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ifu_word_fifo : address-tagged word buffer, one push and a one- or two-entry pop
// Rev 1.0
// ----------------------------------------------------------------------------
module ifu_word_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               push_i,
  input  ifu_entry_t         data_i,
  input  logic               pop1_i,
  input  logic               pop2_i,
  output ifu_entry_t         head0_o,
  output logic [WORD_W-1:0]  head1_word_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  ifu_entry_t       mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] w_pop_n;

  always_comb begin
    w_pop_n = '0;
    if (pop2_i)      w_pop_n = CNT_W'(2);
    else if (pop1_i) w_pop_n = CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_q + w_pop_n[AW-1:0];
      count_q  <= count_q + CNT_W'(push_i) - w_pop_n;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i && !rst) mem_q[wr_ptr_q] <= data_i;
  end

  assign head0_o      = mem_q[rd_ptr_q];
  assign head1_word_o = mem_q[rd_ptr_q + AW'(1)].word;
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instruction_fetch_unit : prefetching fetch unit for 16-bit program memory.
// IFU_TWO_WORD_EN enables pairing of JMP/CALL/LDS/STS opcodes with their operand word.
// Rev 1.0
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 14'h0000,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   PC,
  output logic              PC_RD,
  input  logic [WORD_W-1:0] Dout,
  input  logic              RDY,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [PC_W-1:0]   inst_pc,
  output logic [WORD_W-1:0] inst_word0,
  output logic [WORD_W-1:0] inst_word1,
  output logic              inst_two_word
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RES_W = CNT_W + 1;

  ifu_state_e        state_q;
  logic [PC_W-1:0]   pc_q;
  logic              rd_inflight_q;
  logic [PC_W-1:0]   rd_pc_q;

  logic [CNT_W-1:0]  w_count;
  logic [RES_W-1:0]  w_reserved;
  ifu_entry_t        w_head0;
  ifu_entry_t        w_push_entry;
  logic [WORD_W-1:0] w_head1_word;
  logic              w_issue;
  logic              w_push;
  logic              w_head_two;
  logic              w_head_avail;
  logic              w_xfer;

  // Entries already held plus the read still in flight must leave room for one more.
  assign w_reserved = {1'b0, w_count} + RES_W'(rd_inflight_q);
  assign w_issue    = !rst && !br_valid && (state_q == RUN) && RDY
                      && (w_reserved < RES_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      rd_inflight_q <= 1'b0;
      rd_pc_q       <= '0;
    end else begin
      rd_inflight_q <= w_issue;
      if (w_issue) rd_pc_q <= pc_q;
      if (br_valid) begin
        state_q <= FLUSH;
        pc_q    <= br_target;
      end else begin
        if (w_issue) pc_q <= pc_q + PC_W'(1);
        case (state_q)
          IDLE:    state_q <= RUN;
          RUN:     if (!RDY) state_q <= HOLD;
          HOLD:    if (RDY) state_q <= RUN;
          FLUSH:   state_q <= RUN;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // A redirect in the data-return cycle squashes the returning word.
  assign w_push       = rd_inflight_q && !br_valid && !rst;
  assign w_push_entry = '{pc: rd_pc_q, word: Dout};

  ifu_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (br_valid),
    .push_i       (w_push),
    .data_i       (w_push_entry),
    .pop1_i       (w_xfer && !w_head_two),
    .pop2_i       (w_xfer && w_head_two),
    .head0_o      (w_head0),
    .head1_word_o (w_head1_word),
    .count_o      (w_count)
  );

`ifdef IFU_TWO_WORD_EN
  assign w_head_two = is_two_word(w_head0.word);
`else
  assign w_head_two = 1'b0;
`endif

  assign w_head_avail = w_head_two ? (w_count >= CNT_W'(2)) : (w_count != '0);
  assign w_xfer       = inst_valid && inst_ready && !br_valid;

  assign PC            = rst ? RESET_VECTOR : pc_q;
  assign PC_RD         = w_issue;
  assign inst_valid    = !rst && w_head_avail;
  assign inst_pc       = inst_valid ? w_head0.pc   : '0;
  assign inst_word0    = inst_valid ? w_head0.word : '0;
  assign inst_two_word = inst_valid && w_head_two;
  assign inst_word1    = inst_two_word ? w_head1_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// tb_instruction_fetch_unit : random and directed stimulus scored against an
// instruction-stream model of program memory.
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [13:0] RV    = 14'h0000;
`ifdef IFU_TWO_WORD_EN
  localparam bit TWO_EN = 1'b1;
`else
  localparam bit TWO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] PC;
  logic        PC_RD;
  logic [15:0] Dout;
  logic        RDY;
  logic        br_valid;
  logic [13:0] br_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [13:0] inst_pc;
  logic [15:0] inst_word0;
  logic [15:0] inst_word1;
  logic        inst_two_word;

  instruction_fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PC(PC), .PC_RD(PC_RD), .Dout(Dout), .RDY(RDY),
    .br_valid(br_valid), .br_target(br_target), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_word0(inst_word0),
    .inst_word1(inst_word1), .inst_two_word(inst_two_word)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16384];
  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [13:0] exp_fetch, stream_pc;
  int          outstanding;
  bit          in_reset;
  bit          pend;
  logic [13:0] pend_addr;
  bit          prev_br, prev_hold;
  logic [13:0] pv_pc;
  logic [15:0] pv_w0, pv_w1;
  logic        pv_two;
  int          n_xfer = 0;
  int          n_rd = 0;
  logic [13:0] lx_pc, last_rd_addr;
  logic [15:0] lx_w0, lx_w1;
  logic        lx_two;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit two_word(input logic [15:0] w);
    return TWO_EN && (((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000));
  endfunction

  task automatic step();
    logic [15:0] w0, w1;
    bit two;
    #1;
    if (!in_reset) begin
      if (!RDY) check("rd_while_busy", PC_RD, 0);
      if (prev_br) check("valid_after_flush", inst_valid, 0);
      if (prev_hold) begin
        check("hold_valid", inst_valid, 1);
        check("hold_pc", inst_pc, pv_pc);
        check("hold_w0", inst_word0, pv_w0);
        check("hold_w1", inst_word1, pv_w1);
        check("hold_two", inst_two_word, pv_two);
      end
      if (PC_RD && !br_valid) begin
        check("fetch_addr", PC, exp_fetch);
        exp_fetch    = exp_fetch + 14'd1;
        outstanding++;
        n_rd++;
        last_rd_addr = PC;
        check("buffer_bound", outstanding <= DEPTH, 1);
      end
      if (inst_valid && inst_ready && !br_valid) begin
        w0  = mem[stream_pc];
        two = two_word(w0);
        w1  = two ? mem[stream_pc + 14'd1] : 16'h0000;
        check("xfer_pc", inst_pc, stream_pc);
        check("xfer_w0", inst_word0, w0);
        check("xfer_two", inst_two_word, two);
        check("xfer_w1", inst_word1, w1);
        lx_pc = inst_pc; lx_w0 = inst_word0; lx_w1 = inst_word1; lx_two = inst_two_word;
        stream_pc   = stream_pc + (two ? 14'd2 : 14'd1);
        outstanding = outstanding - (two ? 2 : 1);
        n_xfer++;
      end
      if (br_valid) begin
        exp_fetch   = br_target;
        stream_pc   = br_target;
        outstanding = 0;
      end
    end
    prev_br   = !in_reset && br_valid;
    prev_hold = !in_reset && inst_valid && !inst_ready && !br_valid;
    pv_pc = inst_pc; pv_w0 = inst_word0; pv_w1 = inst_word1; pv_two = inst_two_word;
    pend      = PC_RD;
    pend_addr = PC;
    @(posedge clk);
    @(negedge clk);
    Dout = pend ? mem[pend_addr] : 16'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_reset = 1'b1; br_valid = 1'b0; inst_ready = 1'b0;
    repeat (cycles) step();
    check("rst_pc", PC, RV);
    check("rst_pc_rd", PC_RD, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_w0", inst_word0, 0);
    check("rst_w1", inst_word1, 0);
    check("rst_two", inst_two_word, 0);
    rst = 1'b0; in_reset = 1'b0;
    exp_fetch = RV; stream_pc = RV; outstanding = 0;
    prev_br = 1'b0; prev_hold = 1'b0;
  endtask

  task automatic wait_xfer(input string tag, input int bound);
    int start, k;
    start = n_xfer; k = 0;
    while (n_xfer == start && k < bound) begin step(); k++; end
    check(tag, n_xfer != start, 1);
  endtask

  task automatic wait_rd(input string tag, input int bound);
    int start, k;
    start = n_rd; k = 0;
    while (n_rd == start && k < bound) begin step(); k++; end
    check(tag, n_rd != start, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs, rs;
    logic [13:0] resume;
    logic [31:0] r;
    for (int i = 0; i < 16384; i++) begin
      r = $urandom;
      case (i % 8)
        3:       mem[i] = 16'h940C | (r[15:0] & 16'h01F3);
        6:       mem[i] = 16'h9000 | (r[15:0] & 16'h03F0);
        default: mem[i] = r[15:0];
      endcase
    end
    mem[14'h0000] = 16'hE0F1;
    mem[14'h0001] = 16'h0000;
    mem[14'h0041] = 16'h940C;
    mem[14'h0042] = 16'h1234;
    mem[14'h3FFF] = 16'h0000;

    rst = 1'b1; RDY = 1'b1; br_valid = 1'b0; br_target = '0; inst_ready = 1'b0; Dout = '0;
    in_reset = 1'b1; pend = 1'b0;
    @(negedge clk);
    do_reset(3);

    // first fetch after reset release
    inst_ready = 1'b1;
    wait_rd("first_rd", 10);
    check("first_rd_addr", last_rd_addr, 14'h0000);
    wait_xfer("first_xfer", 10);
    check("first_pc", lx_pc, 14'h0000);
    check("first_w0", lx_w0, 16'hE0F1);
    check("first_two", lx_two, 0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      RDY        = ($urandom_range(0, 7) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      br_valid   = ($urandom_range(0, 29) == 0);
      br_target  = ($urandom_range(0, 3) == 0) ? 14'h3FFC + 14'($urandom_range(0, 3))
                                               : 14'($urandom);
      step();
    end
    br_valid = 1'b0; RDY = 1'b1;

    // two-word jump at 0x0041
    inst_ready = 1'b0; br_valid = 1'b1; br_target = 14'h0041;
    step();
    br_valid = 1'b0;
    repeat (8) step();
    inst_ready = 1'b1;
    wait_xfer("jmp_xfer", 4);
    check("jmp_pc", lx_pc, 14'h0041);
    check("jmp_w0", lx_w0, 16'h940C);
    check("jmp_two", lx_two, TWO_EN);
    check("jmp_w1", lx_w1, TWO_EN ? 16'h1234 : 16'h0000);

    // decoder stall: buffer fills to depth, outputs frozen
    inst_ready = 1'b0;
    repeat (6) step();
    rs = n_rd;
    repeat (4) step();
    check("stall_fill", outstanding, DEPTH);
    check("stall_no_rd", n_rd, rs);
    check("stall_valid", inst_valid, 1);
    check("stall_pc", inst_pc, stream_pc);

    // redirect with a read in flight
    inst_ready = 1'b1;
    wait_rd("pre_br_rd", 10);
    br_valid = 1'b1; br_target = 14'h0100;
    step();
    br_valid = 1'b0;
    wait_xfer("br_xfer", 10);
    check("br_pc", lx_pc, 14'h0100);

    // memory busy: no reads, buffer drains, resume at next address
    inst_ready = 1'b0;
    repeat (6) step();
    inst_ready = 1'b1; RDY = 1'b0;
    xs = n_xfer; rs = n_rd;
    repeat (20) step();
    check("busy_drained", n_xfer > xs, 1);
    check("busy_no_rd", n_rd, rs);
    check("busy_left", outstanding <= 1, 1);
    resume = exp_fetch;
    RDY = 1'b1;
    wait_rd("resume_rd", 10);
    check("resume_addr", last_rd_addr, resume);

    // address wrap
    br_valid = 1'b1; br_target = 14'h3FFF;
    step();
    br_valid = 1'b0;
    wait_rd("wrap_rd0", 10);
    check("wrap_first", last_rd_addr, 14'h3FFF);
    wait_rd("wrap_rd1", 10);
    check("wrap_next", last_rd_addr, 14'h0000);
    wait_xfer("wrap_xfer0", 10);
    check("wrap_pc0", lx_pc, 14'h3FFF);
    wait_xfer("wrap_xfer1", 10);
    check("wrap_pc1", lx_pc, 14'h0000);

    // reset while a read is in flight
    wait_rd("pre_rst_rd", 10);
    do_reset(2);
    inst_ready = 1'b1;
    wait_xfer("post_rst_xfer", 12);
    check("post_rst_pc", lx_pc, RV);
    check("post_rst_w0", lx_w0, 16'hE0F1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 14'h0000: word address fetched first after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: word-buffer entries, power of two, minimum 4.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PC  output  14  word address to program memory.
REQ-006 SHALL have port PC_RD  output  1  read strobe to program memory.
REQ-007 SHALL have port Dout  input  16  program-memory read word, valid exactly one cycle after PC_RD high.
REQ-008 SHALL have port RDY  input  1  program memory ready; low = programming/erase busy, no reads issued.
REQ-009 SHALL have port br_valid  input  1  redirect request from core.
REQ-010 SHALL have port br_target  input  14  redirect word address.
REQ-011 SHALL have port inst_valid  output  1  instruction presented.
REQ-012 SHALL have port inst_ready  input  1  decoder accepts instruction.
REQ-013 SHALL have port inst_pc  output  14  address of first word.
REQ-014 SHALL have port inst_word0  output  16  first opcode word.
REQ-015 SHALL have port inst_word1  output  16  second word (two-word instructions), else 0.
REQ-016 SHALL have port inst_two_word  output  1  instruction is two words.

Function
REQ-017 SHALL transfer an instruction only in a cycle with inst_valid and inst_ready both high; outputs held stable while inst_valid high and inst_ready low.
REQ-018 SHALL assert PC_RD only when RDY high and free FIFO entries exceed in-flight reads; PC increments by 1 per issued read, 14'h3FFF wraps to 14'h0000.
REQ-019 SHALL write Dout, tagged with its address, into the FIFO on the cycle after each issued read unless squashed.
REQ-020 SHALL classify a head word as two-word when (w & 16'hFE0C)==16'h940C (JMP/CALL) or (w & 16'hFC0F)==16'h9000 (LDS/STS).
REQ-021 SHALL assert inst_valid for a one-word head when FIFO holds >=1 entry, for a two-word head only when >=2 entries; a transfer pops 1 or 2 entries.
REQ-022 SHALL implement states IDLE, RUN, HOLD, FLUSH: IDLE->RUN one cycle after reset release; RUN->HOLD when RDY low; HOLD->RUN when RDY high; any->FLUSH on br_valid; FLUSH->RUN next cycle.
REQ-023 SHALL, on br_valid, clear the FIFO, squash any in-flight read, drive inst_valid low next cycle, load PC with br_target, and give br_valid priority over a simultaneous transfer or FIFO write.
REQ-024 SHALL, in HOLD, keep FIFO contents and keep presenting buffered instructions; an in-flight read issued before RDY fell still completes.
REQ-025 SHALL allow simultaneous push and pop in one cycle when full; no overflow, no read issued into a full FIFO.

Reset
REQ-026 SHALL while rst high drive PC=RESET_VECTOR, PC_RD=0, inst_valid=0, inst_pc=0, inst_word0=0, inst_word1=0, inst_two_word=0, FIFO empty, state IDLE.
REQ-027 SHALL discard a read in flight when rst asserts mid-operation; its Dout never enters the FIFO.

Configuration
REQ-028 SHALL with macro IFU_TWO_WORD_EN defined, implement REQ-020/REQ-021 pairing; without it, treat every word as one-word, inst_two_word tied 0, inst_word1 tied 0.

Structure
REQ-029 SHALL place PC_W=14, opcode masks/values, state enum and FIFO entry struct (pc, word) in package ifu_pkg.
REQ-030 SHALL implement the buffer as sub-module ifu_word_fifo with push, pop1, pop2, clear, count outputs.

Verification
REQ-031 SHALL cover reset release, memory words 0x0000:E0F1, 0x0001:0000 -> PC_RD at 14'h0000, inst_word0=16'hE0F1, inst_pc=0, inst_two_word=0.
REQ-032 SHALL cover JMP 0x940C at 0x0041, 0x0042:0x1234 -> one transfer, inst_word0=16'h940C, inst_word1=16'h1234, inst_pc=14'h0041, inst_two_word=1.
REQ-033 SHALL cover inst_ready low 10 cycles -> PC_RD stops after FIFO_DEPTH words buffered, outputs unchanged.
REQ-034 SHALL cover br_valid with br_target=14'h0100 while read in flight -> squashed word never presented, next inst_pc=14'h0100.
REQ-035 SHALL cover RDY low 20 cycles -> no PC_RD, buffered instructions still drained; RDY high -> fetch resumes at next address.
REQ-036 SHALL cover start at 14'h3FFF -> next fetch address 14'h0000.
